// File: rtl/enemy_patrol.sv
// Enemy patrol controller: moves one enemy's x coordinate between two bounds
// on a divided tick, in bounce or wrap mode. It also tracks the
// alive/dead/respawn lifecycle and raises periodic fire requests that are
// handed to the projectile allocator with a req/ack handshake.
module enemy_patrol #(
    parameter int unsigned X_WIDTH       = 8,
    parameter int unsigned X_MIN         = 0,
    parameter int unsigned X_MAX         = 160,
    parameter int unsigned STEP_WIDTH    = 4,
    parameter int unsigned TICK_DIV      = 25000000,
    parameter int unsigned FIRE_PERIOD   = 8,
    parameter int unsigned RESPAWN_TICKS = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  mode,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic                  hit,
    input  logic                  respawn,
    input  logic                  fire_ack,
    output logic [X_WIDTH-1:0]    x,
    output logic                  dir_left,
    output logic                  alive,
    output logic                  tick,
    output logic                  fire_req,
    output logic [X_WIDTH-1:0]    fire_x
);

    localparam int unsigned XW1   = X_WIDTH + 1;
    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned FC_W  = (FIRE_PERIOD > 1) ? $clog2(FIRE_PERIOD) : 1;
    localparam int unsigned RC_W  = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;

    localparam logic [XW1-1:0]     XMIN_E     = XW1'(X_MIN);
    localparam logic [XW1-1:0]     XMAX_E     = XW1'(X_MAX);
    localparam logic [X_WIDTH-1:0] XMIN_X     = X_WIDTH'(X_MIN);
    localparam logic [X_WIDTH-1:0] XMAX_X     = X_WIDTH'(X_MAX);
    localparam logic [DIV_W-1:0]   DIV_RELOAD = DIV_W'(TICK_DIV - 1);
    localparam logic [FC_W-1:0]    FC_LAST    = FC_W'(FIRE_PERIOD - 1);
    localparam logic [RC_W-1:0]    RC_LAST    = RC_W'(RESPAWN_TICKS - 1);

    typedef enum logic {
        S_ALIVE,
        S_DEAD
    } state_e;

    state_e               state_q;
    logic [DIV_W-1:0]     div_q;
    logic                 tick_q;
    logic [X_WIDTH-1:0]   x_q;
    logic                 dir_q;
    logic                 fire_req_q;
    logic [X_WIDTH-1:0]   fire_x_q;
    logic [FC_W-1:0]      fc_q;
    logic [RC_W-1:0]      rc_q;

    logic [X_WIDTH-1:0]   x_move_d;
    logic                 dir_move_d;
    logic [XW1-1:0]       cur_w;
    logic [XW1-1:0]       stp_w;
    logic [XW1-1:0]       sum_w;
    logic [XW1-1:0]       lim_w;

    assign cur_w = {1'b0, x_q};
    assign stp_w = XW1'(step);
    assign sum_w = cur_w + stp_w;
    assign lim_w = XMIN_E + stp_w;

    // Tick divider: counts enabled cycles, registered one-cycle tick pulse at wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_q  <= DIV_RELOAD;
            tick_q <= 1'b0;
        end else begin
            tick_q <= enable && (div_q == '0);
            if (enable) begin
                div_q <= (div_q == '0) ? DIV_RELOAD : div_q - DIV_W'(1);
            end
        end
    end

    // Next position/direction for one movement step, computed one bit wider.
    always_comb begin
        x_move_d   = x_q;
        dir_move_d = dir_q;
        if (!dir_q) begin
            if (mode) begin
                x_move_d = (sum_w > XMAX_E) ? XMIN_X : X_WIDTH'(sum_w);
            end else if (sum_w >= XMAX_E) begin
                x_move_d   = XMAX_X;
                dir_move_d = 1'b1;
            end else begin
                x_move_d = X_WIDTH'(sum_w);
            end
        end else begin
            if (mode) begin
                x_move_d = (cur_w < lim_w) ? XMAX_X : X_WIDTH'(cur_w - stp_w);
            end else if ((cur_w < lim_w) || (cur_w == XMIN_E)) begin
                // The equality term lets a zero step still turn around at X_MIN.
                x_move_d   = XMIN_X;
                dir_move_d = 1'b0;
            end else begin
                x_move_d = X_WIDTH'(cur_w - stp_w);
            end
        end
    end

    // Lifecycle FSM with motion, fire handshake and respawn counting.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_ALIVE;
            x_q        <= XMIN_X;
            dir_q      <= 1'b0;
            fire_req_q <= 1'b0;
            fire_x_q   <= '0;
            fc_q       <= '0;
            rc_q       <= '0;
        end else begin
            case (state_q)
                S_ALIVE: begin
                    if (hit) begin
                        // A kill overrides any same-cycle move or acknowledge.
                        state_q    <= S_DEAD;
                        fire_req_q <= 1'b0;
                        fc_q       <= '0;
                        rc_q       <= '0;
                    end else begin
                        if (fire_req_q && fire_ack) begin
                            fire_req_q <= 1'b0;
                        end
                        if (tick_q) begin
                            x_q   <= x_move_d;
                            dir_q <= dir_move_d;
                            if (fc_q == FC_LAST) begin
                                fc_q <= '0;
                                if (!fire_req_q) begin
                                    fire_req_q <= 1'b1;
                                    fire_x_q   <= x_q;
                                end
                            end else begin
                                fc_q <= fc_q + FC_W'(1);
                            end
                        end
                    end
                end
                S_DEAD: begin
                    if (respawn || (tick_q && (rc_q == RC_LAST))) begin
                        state_q <= S_ALIVE;
                        x_q     <= XMIN_X;
                        dir_q   <= 1'b0;
                        rc_q    <= '0;
                    end else if (tick_q) begin
                        rc_q <= rc_q + RC_W'(1);
                    end
                end
                default: state_q <= S_ALIVE;
            endcase
        end
    end

    assign x        = x_q;
    assign dir_left = dir_q;
    assign alive    = (state_q == S_ALIVE);
    assign tick     = tick_q;
    assign fire_req = fire_req_q;
    assign fire_x   = fire_x_q;

endmodule

// File: tb/tb_enemy_patrol.sv
// Self-checking bench for enemy_patrol: a directed vector table, hand-written
// lifecycle/handshake/reset sequences and a randomized run, all compared every
// cycle against a cycle-level behavioural model.
module tb_enemy_patrol;

    localparam int X_WIDTH       = 8;
    localparam int X_MIN         = 0;
    localparam int X_MAX         = 10;
    localparam int STEP_WIDTH    = 4;
    localparam int TICK_DIV      = 4;
    localparam int FIRE_PERIOD   = 2;
    localparam int RESPAWN_TICKS = 3;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic                  enable = 1'b1;
    logic                  mode = 1'b0;
    logic [STEP_WIDTH-1:0] step = 4'd3;
    logic                  hit = 1'b0;
    logic                  respawn = 1'b0;
    logic                  fire_ack = 1'b0;
    logic [X_WIDTH-1:0]    x;
    logic                  dir_left;
    logic                  alive;
    logic                  tick;
    logic                  fire_req;
    logic [X_WIDTH-1:0]    fire_x;

    enemy_patrol #(
        .X_WIDTH      (X_WIDTH),
        .X_MIN        (X_MIN),
        .X_MAX        (X_MAX),
        .STEP_WIDTH   (STEP_WIDTH),
        .TICK_DIV     (TICK_DIV),
        .FIRE_PERIOD  (FIRE_PERIOD),
        .RESPAWN_TICKS(RESPAWN_TICKS)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .mode    (mode),
        .step    (step),
        .hit     (hit),
        .respawn (respawn),
        .fire_ack(fire_ack),
        .x       (x),
        .dir_left(dir_left),
        .alive   (alive),
        .tick    (tick),
        .fire_req(fire_req),
        .fire_x  (fire_x)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural reference: tick = every TICK_DIV-th enabled cycle since reset,
    // fire = every FIRE_PERIOD-th tick while alive, revive after RESPAWN_TICKS ticks.
    int m_en_cnt, m_x, m_fx, m_fire_ticks, m_dead_ticks;
    bit m_tick, m_dir, m_alive, m_freq;

    task automatic m_reset();
        m_en_cnt = 0; m_tick = 0; m_x = X_MIN; m_dir = 0; m_alive = 1;
        m_freq = 0; m_fx = 0; m_fire_ticks = 0; m_dead_ticks = 0;
    endtask

    task automatic m_move();
        int s;
        int t;
        s = int'(step);
        if (!m_dir) begin
            t = m_x + s;
            if (mode) m_x = (t > X_MAX) ? X_MIN : t;
            else if (t >= X_MAX) begin m_x = X_MAX; m_dir = 1; end
            else m_x = t;
        end else begin
            t = m_x - s;
            if (mode) m_x = (t < X_MIN) ? X_MAX : t;
            else if (t < X_MIN || m_x == X_MIN) begin m_x = X_MIN; m_dir = 0; end
            else m_x = t;
        end
    endtask

    task automatic m_step();
        bit old_tick;
        bit old_freq;
        old_tick = m_tick;
        old_freq = m_freq;
        if (enable) begin
            m_en_cnt++;
            m_tick = (m_en_cnt % TICK_DIV) == 0;
        end else begin
            m_tick = 0;
        end
        if (m_alive) begin
            if (hit) begin
                m_alive = 0; m_freq = 0; m_fire_ticks = 0; m_dead_ticks = 0;
            end else begin
                if (old_freq && fire_ack) m_freq = 0;
                if (old_tick) begin
                    m_fire_ticks++;
                    if (m_fire_ticks == FIRE_PERIOD) begin
                        m_fire_ticks = 0;
                        if (!old_freq) begin m_freq = 1; m_fx = m_x; end
                    end
                    m_move();
                end
            end
        end else begin
            if (respawn) begin
                m_alive = 1; m_x = X_MIN; m_dir = 0;
            end else if (old_tick) begin
                m_dead_ticks++;
                if (m_dead_ticks == RESPAWN_TICKS) begin
                    m_alive = 1; m_x = X_MIN; m_dir = 0;
                end
            end
        end
    endtask

    task automatic cmp_model(input string where);
        check({where, " x"},        32'(x),        32'(m_x));
        check({where, " dir_left"}, 32'(dir_left), 32'(m_dir));
        check({where, " alive"},    32'(alive),    32'(m_alive));
        check({where, " tick"},     32'(tick),     32'(m_tick));
        check({where, " fire_req"}, 32'(fire_req), 32'(m_freq));
        check({where, " fire_x"},   32'(fire_x),   32'(m_fx));
    endtask

    // One clock: model consumes the inputs present at the edge, compare #1 later.
    task automatic cyc();
        @(posedge clock);
        if (!reset) m_reset();
        else m_step();
        #1;
        cmp_model("model");
    endtask

    task automatic assert_reset();
        reset = 1'b0;
        #1;
        m_reset();
    endtask

    task automatic do_reset();
        assert_reset();
        cyc();
        cyc();
        hit = 0; respawn = 0; fire_ack = 0; enable = 1; mode = 0; step = 4'd3;
        reset = 1'b1;
    endtask

    typedef struct {
        int n;
        bit en;
        bit md;
        int st;
        bit ack;
        int ex;
        int ed;
        int ef;
        int efx;
    } vec_t;

    function automatic vec_t mk(int n, bit md, int st, int ex, int ed, int ef, int efx);
        vec_t v;
        v.n = n; v.en = 1; v.md = md; v.st = st; v.ack = 1;
        v.ex = ex; v.ed = ed; v.ef = ef; v.efx = efx;
        return v;
    endfunction

    vec_t tbl[15];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [X_WIDTH-1:0] xs;

        // Bounce run from reset (ack held high), then wrap, then zero step.
        tbl[0]  = mk(5, 0, 3, 3,  0, 0, -1);
        tbl[1]  = mk(4, 0, 3, 6,  0, 1, 3);
        tbl[2]  = mk(4, 0, 3, 9,  0, 0, -1);
        tbl[3]  = mk(4, 0, 3, 10, 1, 1, 9);
        tbl[4]  = mk(4, 0, 3, 7,  1, 0, -1);
        tbl[5]  = mk(4, 0, 3, 4,  1, 1, 7);
        tbl[6]  = mk(4, 0, 3, 1,  1, 0, -1);
        tbl[7]  = mk(4, 0, 3, 0,  0, 1, 1);
        tbl[8]  = mk(4, 0, 3, 3,  0, 0, -1);
        tbl[9]  = mk(4, 1, 3, 6,  0, 1, 3);
        tbl[10] = mk(4, 1, 3, 9,  0, 0, -1);
        tbl[11] = mk(4, 1, 3, 0,  0, 1, 9);
        tbl[12] = mk(4, 1, 3, 3,  0, 0, -1);
        tbl[13] = mk(4, 0, 0, 3,  0, 1, 3);
        tbl[14] = mk(4, 0, 0, 3,  0, 0, -1);

        m_reset();
        #1;
        cmp_model("reset");
        do_reset();

        for (int r = 0; r < 15; r++) begin
            enable = tbl[r].en; mode = tbl[r].md; step = 4'(tbl[r].st); fire_ack = tbl[r].ack;
            repeat (tbl[r].n) cyc();
            check($sformatf("row%0d x", r),        32'(x),        32'(tbl[r].ex));
            check($sformatf("row%0d dir", r),      32'(dir_left), 32'(tbl[r].ed));
            check($sformatf("row%0d alive", r),    32'(alive),    32'd1);
            check($sformatf("row%0d fire_req", r), 32'(fire_req), 32'(tbl[r].ef));
            if (tbl[r].efx >= 0) check($sformatf("row%0d fire_x", r), 32'(fire_x), 32'(tbl[r].efx));
        end

        // Fire request held without ack; later shots are dropped.
        do_reset();
        repeat (9) cyc();
        check("hold fire_req", 32'(fire_req), 32'd1);
        check("hold fire_x",   32'(fire_x),   32'd3);
        repeat (8) cyc();
        check("hold2 fire_req", 32'(fire_req), 32'd1);
        check("hold2 fire_x",   32'(fire_x),   32'd3);
        check("hold2 x",        32'(x),        32'd10);
        fire_ack = 1; cyc(); fire_ack = 0;
        check("ack fire_req", 32'(fire_req), 32'd0);

        // Hit on a tick cycle, automatic respawn, forced respawn, enable freeze.
        do_reset();
        repeat (12) cyc();
        check("pre-hit tick", 32'(tick), 32'd1);
        check("pre-hit x",    32'(x),    32'd6);
        hit = 1; fire_ack = 1; cyc(); hit = 0; fire_ack = 0;
        check("hit alive",    32'(alive),    32'd0);
        check("hit x",        32'(x),        32'd6);
        check("hit fire_req", 32'(fire_req), 32'd0);
        repeat (11) cyc();
        check("dead alive", 32'(alive), 32'd0);
        cyc();
        check("revive alive", 32'(alive),    32'd1);
        check("revive x",     32'(x),        32'd0);
        check("revive dir",   32'(dir_left), 32'd0);
        repeat (8) cyc();
        hit = 1; cyc(); hit = 0;
        check("hit2 alive", 32'(alive), 32'd0);
        respawn = 1; cyc(); respawn = 0;
        check("respawn alive", 32'(alive), 32'd1);
        check("respawn x",     32'(x),     32'd0);
        n = 0;
        while (!tick && n < 10) begin cyc(); n++; end
        check("tick seen", 32'(tick), 32'd1);
        enable = 0;
        cyc();
        xs = x;
        for (int i = 0; i < 10; i++) begin
            check("freeze tick", 32'(tick), 32'd0);
            check("freeze x",    32'(x),    32'(xs));
            if (i < 9) cyc();
        end
        enable = 1;
        n = 0;
        while (n < 20) begin cyc(); n++; if (tick) break; end
        check("resume tick latency", 32'(n), 32'(TICK_DIV));

        // Asynchronous reset during a pending fire request.
        do_reset();
        repeat (13) cyc();
        check("pre-rst x",        32'(x),        32'd9);
        check("pre-rst fire_req", 32'(fire_req), 32'd1);
        assert_reset();
        check("async x",        32'(x),        32'd0);
        check("async fire_req", 32'(fire_req), 32'd0);
        cyc();
        reset = 1'b1;
        n = 0;
        while (n < 20) begin cyc(); n++; if (tick) break; end
        check("first tick latency", 32'(n), 32'(TICK_DIV));

        // Wrap while moving left.
        do_reset();
        repeat (29) cyc();
        check("pre-wrap x",   32'(x),        32'd1);
        check("pre-wrap dir", 32'(dir_left), 32'd1);
        mode = 1;
        repeat (4) cyc();
        check("wrap-left x",   32'(x),        32'd10);
        check("wrap-left dir", 32'(dir_left), 32'd1);
        repeat (4) cyc();
        check("wrap-left2 x", 32'(x), 32'd7);

        // Randomized run against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            enable   = ($urandom % 10) != 0;
            if (($urandom % 50) == 0) mode = ~mode;
            step     = 4'($urandom % 16);
            hit      = ($urandom % 40) == 0;
            respawn  = ($urandom % 30) == 0;
            fire_ack = ($urandom % 3) == 0;
            if (($urandom % 700) == 0) do_reset();
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
